note_lane_scheduler: RTL and testbench

// Sequences the arrow-dropper lanes of the rhythm game. Steps through a chart of (frame, lane) spawn entries
// and pulses a spawn strobe to the matching dropper lane. Tracks which lanes hold a live arrow and collects
// per-lane hit/miss reports into score, combo and hit/miss counters. Sits between keyboard keycode decode,
// the chart ROM and the dropper array; runs on frame_clk.

---
 rtl/note_lane_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_note_lane_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//   Sequences the arrow-dropper lanes of the rhythm game. Walks a chart of
//   (frame, lane) spawn entries and pulses a one-cycle spawn strobe to the
//   matching dropper lane. Tracks which lanes hold a live arrow and folds
//   per-lane hit/miss reports into score, combo and hit/miss counters.
//
// Ports
//   frame_clk       frame clock (single clock domain)
//   Reset           asynchronous active-low reset
//   keycode         primary keycode from the keyboard decoder
//   keycode_second  secondary keycode from the keyboard decoder
//   chart_addr      chart ROM address (ROM is combinational-read)
//   chart_time      frame number at which the addressed entry spawns
//   chart_lane      lane of the addressed entry
//   chart_valid     0 marks the end of the chart
//   lane_hit        per-lane pulse: arrow hit inside the window
//   lane_miss       per-lane pulse: arrow reached the bottom
//   spawn           one-cycle spawn strobe to a dropper lane (one-hot or zero)
//   lane_active     lane currently holds a live arrow
//   frame_cnt       frames elapsed in RUN (saturating)
//   score           accumulated score (saturating)
//   combo           current consecutive-hit count (saturating)
//   max_combo       best combo of the run
//   hit_cnt         total hits (saturating)
//   miss_cnt        total misses (saturating)
//   run_state       0 IDLE, 1 RUN, 2 DONE

module note_lane_scheduler #(
  parameter int          NUM_LANES  = 4,
  parameter int          CHART_AW   = 6,
  parameter int          HIT_POINTS = 10,
  parameter logic [7:0]  START_KEY  = 8'h2C,
  parameter logic [7:0]  RESET_KEY  = 8'h01,
  localparam int         LW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [7:0]            keycode,
  input  logic [7:0]            keycode_second,
  output logic [CHART_AW-1:0]   chart_addr,
  input  logic [11:0]           chart_time,
  input  logic [LW-1:0]         chart_lane,
  input  logic                  chart_valid,
  input  logic [NUM_LANES-1:0]  lane_hit,
  input  logic [NUM_LANES-1:0]  lane_miss,
  output logic [NUM_LANES-1:0]  spawn,
  output logic [NUM_LANES-1:0]  lane_active,
  output logic [11:0]           frame_cnt,
  output logic [15:0]           score,
  output logic [7:0]            combo,
  output logic [7:0]            max_combo,
  output logic [7:0]            hit_cnt,
  output logic [7:0]            miss_cnt,
  output logic [1:0]            run_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CHART_AW-1:0] LAST_ADDR = '1;

  state_t                 state_q, state_d;
  logic [CHART_AW-1:0]    chart_addr_q, chart_addr_d;
  logic                   exhausted_q, exhausted_d;
  logic [NUM_LANES-1:0]   lane_active_q, lane_active_d;
  logic [11:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            score_q, score_d;
  logic [7:0]             combo_q, combo_d;
  logic [7:0]             max_combo_q, max_combo_d;
  logic [7:0]             hit_cnt_q, hit_cnt_d;
  logic [7:0]             miss_cnt_q, miss_cnt_d;

  logic [NUM_LANES-1:0]   spawn_vec;
  logic                   spawn_fire;
  logic [NUM_LANES-1:0]   valid_hit;
  logic [NUM_LANES-1:0]   valid_miss;
  logic [7:0]             hit_num;
  logic [7:0]             miss_num;
  logic [16:0]            score_sum;
  logic [8:0]             combo_sum;
  logic [8:0]             hit_sum;
  logic [8:0]             miss_sum;
  logic                   start_key;
  logic                   reset_key;
  logic                   chart_done;

  assign start_key  = (keycode == START_KEY) || (keycode_second == START_KEY);
  assign reset_key  = (keycode == RESET_KEY) || (keycode_second == RESET_KEY);
  // Once the final ROM address has spawned, the chart is treated as ended
  // even if that address never carried an end marker.
  assign chart_done = !chart_valid || exhausted_q;

  // The head chart entry spawns only when it is due and its lane is free.
  // A blocked head entry holds back everything behind it (in-order chart).
  always_comb begin
    spawn_vec  = '0;
    spawn_fire = 1'b0;
    if (state_q == ST_RUN && !chart_done && frame_cnt_q >= chart_time &&
        !lane_active_q[chart_lane]) begin
      spawn_fire            = 1'b1;
      spawn_vec[chart_lane] = 1'b1;
    end
  end

  // Reports only count against live arrows; a hit masks a miss on the same
  // lane in the same cycle.
  always_comb begin
    valid_hit  = '0;
    valid_miss = '0;
    if (state_q == ST_RUN) begin
      valid_hit  = lane_hit & lane_active_q;
      valid_miss = lane_miss & lane_active_q & ~lane_hit;
    end
  end

  always_comb begin
    hit_num  = '0;
    miss_num = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_num  = hit_num + 8'(valid_hit[i]);
      miss_num = miss_num + 8'(valid_miss[i]);
    end
  end

  // Wide sums so saturation is a simple carry-out check.
  assign score_sum = {1'b0, score_q} + 17'(hit_num * 8'(HIT_POINTS));
  assign combo_sum = {1'b0, combo_q} + {1'b0, hit_num};
  assign hit_sum   = {1'b0, hit_cnt_q} + {1'b0, hit_num};
  assign miss_sum  = {1'b0, miss_cnt_q} + {1'b0, miss_num};

  // Run-state machine and all statistics updates.
  always_comb begin
    state_d       = state_q;
    chart_addr_d  = chart_addr_q;
    exhausted_d   = exhausted_q;
    lane_active_d = lane_active_q;
    frame_cnt_d   = frame_cnt_q;
    score_d       = score_q;
    combo_d       = combo_q;
    max_combo_d   = max_combo_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_key) begin
          state_d       = ST_RUN;
          chart_addr_d  = '0;
          exhausted_d   = 1'b0;
          lane_active_d = '0;
          frame_cnt_d   = '0;
          score_d       = '0;
          combo_d       = '0;
          max_combo_d   = '0;
          hit_cnt_d     = '0;
          miss_cnt_d    = '0;
        end
      end

      ST_RUN: begin
        if (frame_cnt_q != 12'hFFF) begin
          frame_cnt_d = frame_cnt_q + 12'd1;
        end

        // Spawn is ORed in after the clear so a lane freed and refilled in
        // the same cycle ends up active.
        lane_active_d = (lane_active_q & ~(valid_hit | valid_miss)) | spawn_vec;

        if (spawn_fire) begin
          if (chart_addr_q == LAST_ADDR) begin
            exhausted_d = 1'b1;
          end else begin
            chart_addr_d = chart_addr_q + 1'b1;
          end
        end

        score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        hit_cnt_d  = hit_sum[8] ? 8'hFF : hit_sum[7:0];
        miss_cnt_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];

        if (miss_num != 8'd0) begin
          combo_d = '0;
        end else begin
          combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;

        if (chart_done && lane_active_q == '0) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (reset_key) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      chart_addr_q  <= '0;
      exhausted_q   <= 1'b0;
      lane_active_q <= '0;
      frame_cnt_q   <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      chart_addr_q  <= chart_addr_d;
      exhausted_q   <= exhausted_d;
      lane_active_q <= lane_active_d;
      frame_cnt_q   <= frame_cnt_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign chart_addr  = chart_addr_q;
  assign spawn       = spawn_vec;
  assign lane_active = lane_active_q;
  assign frame_cnt   = frame_cnt_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign run_state   = state_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// tb_note_lane_scheduler
//   Directed bench for note_lane_scheduler. A small chart ROM is modelled
//   here; each scenario loads a chart, pushes the spawn pulses it expects
//   into a queue, and a monitor pops one entry whenever the DUT strobes
//   spawn. Register-style outputs are compared against hand-computed values.

module tb_note_lane_scheduler;

  typedef struct packed {
    logic [3:0]  spawnVec;
    logic [11:0] frame;
  } spawn_exp_t;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic [7:0]  keycode_second;
  logic [5:0]  chart_addr;
  logic [11:0] chart_time;
  logic [1:0]  chart_lane;
  logic        chart_valid;
  logic [3:0]  lane_hit;
  logic [3:0]  lane_miss;
  logic [3:0]  spawn;
  logic [3:0]  lane_active;
  logic [11:0] frame_cnt;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;
  logic [1:0]  run_state;

  logic        romValid [64];
  logic [11:0] romTime  [64];
  logic [1:0]  romLane  [64];

  spawn_exp_t  expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;

  note_lane_scheduler dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .chart_addr     (chart_addr),
    .chart_time     (chart_time),
    .chart_lane     (chart_lane),
    .chart_valid    (chart_valid),
    .lane_hit       (lane_hit),
    .lane_miss      (lane_miss),
    .spawn          (spawn),
    .lane_active    (lane_active),
    .frame_cnt      (frame_cnt),
    .score          (score),
    .combo          (combo),
    .max_combo      (max_combo),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .run_state      (run_state)
  );

  // Combinational-read chart ROM
  assign chart_valid = romValid[chart_addr];
  assign chart_time  = romTime[chart_addr];
  assign chart_lane  = romLane[chart_addr];

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // Compare one observed value against its required value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Spawn monitor: every strobe must match the oldest queued expectation
  always @(negedge frame_clk) begin
    if (Reset && spawn != 4'b0000) begin
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL unexpected_spawn actual=%b@%0d required=none", spawn, frame_cnt);
      end else begin
        spawn_exp_t e;
        e = expQ.pop_front();
        if (spawn !== e.spawnVec || frame_cnt !== e.frame) begin
          errorCount++;
          $display("[TB] FAIL spawn actual=%b@%0d required=%b@%0d",
                   spawn, frame_cnt, e.spawnVec, e.frame);
        end
      end
    end
  end

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      @(negedge frame_clk);
    end
  endtask

  // Drive one cycle of key/report inputs, then return them to idle
  task automatic applyStimulus(input logic [7:0] key, input logic [7:0] key2,
                               input logic [3:0] hit, input logic [3:0] miss);
    keycode        = key;
    keycode_second = key2;
    lane_hit       = hit;
    lane_miss      = miss;
    stepCycles(1);
    keycode        = 8'h00;
    keycode_second = 8'h00;
    lane_hit       = 4'b0000;
    lane_miss      = 4'b0000;
  endtask

  task automatic clearChart();
    for (int i = 0; i < 64; i++) begin
      romValid[i] = 1'b0;
      romTime[i]  = 12'd0;
      romLane[i]  = 2'd0;
    end
  endtask

  task automatic setEntry(input int idx, input logic [11:0] t, input logic [1:0] l);
    romValid[idx] = 1'b1;
    romTime[idx]  = t;
    romLane[idx]  = l;
  endtask

  task automatic pushSpawn(input logic [3:0] s, input logic [11:0] f);
    spawn_exp_t e;
    e.spawnVec = s;
    e.frame    = f;
    expQ.push_back(e);
  endtask

  initial begin
    Reset          = 1'b0;
    keycode        = 8'h00;
    keycode_second = 8'h00;
    lane_hit       = 4'b0000;
    lane_miss      = 4'b0000;
    clearChart();

    #1;
    checkOutput("reset_state", 32'(run_state), 32'd0);
    checkOutput("reset_addr", 32'(chart_addr), 32'd0);
    @(negedge frame_clk);
    Reset = 1'b1;
    @(negedge frame_clk);

    // Single entry spawns at its frame, then end marker waits for the lane
    $display("[TB] scenario: single spawn and end of chart");
    setEntry(0, 12'd5, 2'd2);
    pushSpawn(4'b0100, 12'd5);
    applyStimulus(8'h2C, 8'h00, 4'b0000, 4'b0000);
    checkOutput("start_state", 32'(run_state), 32'd1);
    checkOutput("start_frame", 32'(frame_cnt), 32'd0);
    stepCycles(5);
    stepCycles(1);
    checkOutput("addr_after_spawn", 32'(chart_addr), 32'd1);
    checkOutput("active_after_spawn", 32'(lane_active), 32'b0100);
    applyStimulus(8'h00, 8'h00, 4'b0000, 4'b0100);
    checkOutput("run_while_active", 32'(run_state), 32'd1);
    checkOutput("miss_cnt_1", 32'(miss_cnt), 32'd1);
    checkOutput("lane_cleared", 32'(lane_active), 32'd0);
    stepCycles(1);
    checkOutput("done_state", 32'(run_state), 32'd2);
    stepCycles(2);
    checkOutput("frame_frozen", 32'(frame_cnt), 32'd8);
    applyStimulus(8'h2C, 8'h00, 4'b0000, 4'b0000);
    checkOutput("done_ignores_start", 32'(run_state), 32'd2);
    applyStimulus(8'h00, 8'h01, 4'b0000, 4'b0000);
    checkOutput("back_to_idle", 32'(run_state), 32'd0);
    checkOutput("idle_holds_stats", 32'(miss_cnt), 32'd1);

    // Second entry on the same lane stalls until the lane is freed
    $display("[TB] scenario: blocked entry");
    clearChart();
    setEntry(0, 12'd3, 2'd1);
    setEntry(1, 12'd4, 2'd1);
    pushSpawn(4'b0010, 12'd3);
    pushSpawn(4'b0010, 12'd21);
    applyStimulus(8'h00, 8'h2C, 4'b0000, 4'b0000);
    checkOutput("restart_clears_miss", 32'(miss_cnt), 32'd0);
    stepCycles(20);
    checkOutput("stalled_addr", 32'(chart_addr), 32'd1);
    checkOutput("stalled_active", 32'(lane_active), 32'b0010);
    applyStimulus(8'h00, 8'h00, 4'b0010, 4'b0000);
    checkOutput("hit_score", 32'(score), 32'd10);
    checkOutput("hit_combo", 32'(combo), 32'd1);
    stepCycles(1);
    checkOutput("refill_addr", 32'(chart_addr), 32'd2);
    checkOutput("refill_active", 32'(lane_active), 32'b0010);
    applyStimulus(8'h00, 8'h00, 4'b0010, 4'b0000);
    checkOutput("score_20", 32'(score), 32'd20);
    checkOutput("combo_2", 32'(combo), 32'd2);
    checkOutput("max_combo_2", 32'(max_combo), 32'd2);
    checkOutput("hit_cnt_2", 32'(hit_cnt), 32'd2);
    stepCycles(1);
    checkOutput("done_after_hits", 32'(run_state), 32'd2);
    applyStimulus(8'h01, 8'h00, 4'b0000, 4'b0000);

    // Simultaneous multi-lane hit/miss, including hit masking a miss
    $display("[TB] scenario: multi-lane reports");
    clearChart();
    setEntry(0, 12'd1, 2'd0);
    setEntry(1, 12'd1, 2'd1);
    setEntry(2, 12'd1, 2'd3);
    pushSpawn(4'b0001, 12'd1);
    pushSpawn(4'b0010, 12'd2);
    pushSpawn(4'b1000, 12'd3);
    applyStimulus(8'h2C, 8'h00, 4'b0000, 4'b0000);
    checkOutput("restart_score_zero", 32'(score), 32'd0);
    checkOutput("restart_hits_zero", 32'(hit_cnt), 32'd0);
    checkOutput("restart_max_zero", 32'(max_combo), 32'd0);
    stepCycles(4);
    checkOutput("three_active", 32'(lane_active), 32'b1011);
    applyStimulus(8'h00, 8'h00, 4'b0011, 4'b1001);
    checkOutput("multi_score", 32'(score), 32'd20);
    checkOutput("multi_hits", 32'(hit_cnt), 32'd2);
    checkOutput("multi_miss", 32'(miss_cnt), 32'd1);
    checkOutput("multi_combo", 32'(combo), 32'd0);
    checkOutput("multi_max", 32'(max_combo), 32'd0);
    checkOutput("multi_cleared", 32'(lane_active), 32'd0);
    stepCycles(1);
    applyStimulus(8'h01, 8'h00, 4'b0000, 4'b0000);

    // Saturation of score and combo from a preloaded near-full state
    $display("[TB] scenario: saturation");
    clearChart();
    setEntry(0, 12'd0, 2'd0);
    setEntry(1, 12'd0, 2'd2);
    pushSpawn(4'b0001, 12'd0);
    pushSpawn(4'b0100, 12'd1);
    applyStimulus(8'h2C, 8'h00, 4'b0000, 4'b0000);
    stepCycles(2);
    checkOutput("sat_active", 32'(lane_active), 32'b0101);
    force dut.score_q     = 16'd65530;
    force dut.combo_q     = 8'd254;
    force dut.max_combo_q = 8'd200;
    #1;
    release dut.score_q;
    release dut.combo_q;
    release dut.max_combo_q;
    applyStimulus(8'h00, 8'h00, 4'b0001, 4'b0000);
    checkOutput("score_sat", 32'(score), 32'hFFFF);
    checkOutput("combo_255", 32'(combo), 32'd255);
    checkOutput("max_combo_255", 32'(max_combo), 32'd255);
    applyStimulus(8'h00, 8'h00, 4'b0100, 4'b0000);
    checkOutput("score_stays_sat", 32'(score), 32'hFFFF);
    checkOutput("combo_stays_255", 32'(combo), 32'd255);
    checkOutput("sat_hit_cnt", 32'(hit_cnt), 32'd2);
    stepCycles(1);
    applyStimulus(8'h01, 8'h00, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a run
    $display("[TB] scenario: async reset mid-run");
    clearChart();
    setEntry(0, 12'd0, 2'd0);
    setEntry(1, 12'd0, 2'd1);
    pushSpawn(4'b0001, 12'd0);
    pushSpawn(4'b0010, 12'd1);
    applyStimulus(8'h2C, 8'h00, 4'b0000, 4'b0000);
    stepCycles(2);
    checkOutput("pre_reset_active", 32'(lane_active), 32'b0011);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("async_state", 32'(run_state), 32'd0);
    checkOutput("async_active", 32'(lane_active), 32'd0);
    checkOutput("async_frame", 32'(frame_cnt), 32'd0);
    checkOutput("async_addr", 32'(chart_addr), 32'd0);
    checkOutput("async_spawn", 32'(spawn), 32'd0);
    checkOutput("async_score", 32'(score), 32'd0);
    @(negedge frame_clk);
    Reset = 1'b1;
    stepCycles(1);

    checkOutput("spawn_queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
